// File: rtl/ladybird_config.sv
// Shared types and constants for the ladybird memory responder.
package ladybird_config;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } engine_state_t;

    // Wide enough to hold any LATENCY in 1..15.
    localparam int LAT_W = 4;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_entry_t;

endpackage

// File: rtl/ladybird_ram.sv
// DEPTH x 32 storage: byte-enabled synchronous write, asynchronous read.
module ladybird_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [3:0]               we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    // One independent array per byte lane so each lane has a single writer.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q [DEPTH];

        always_ff @(posedge clk) begin
            if (we_i[gi]) begin
                lane_q[addr_i] <= wdata_i[gi*8 +: 8];
            end
        end

        assign rdata_o[gi*8 +: 8] = lane_q[addr_i];
    end

endmodule

// File: rtl/ladybird_mem_responder.sv
// Memory responder: 2-entry request FIFO in front of a fixed-latency service
// engine that answers each request with a one-cycle data_gnt pulse.
module ladybird_mem_responder
    import ladybird_config::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        gnt,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        data_gnt,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

    req_entry_t       fifo_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    engine_state_t    state_q;
    engine_state_t    state_d;
    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    logic             push;
    logic             pop;
    logic             more_pending;
    req_entry_t       head;
    logic             head_in_range;
    logic             head_is_read;
    logic [3:0]       ram_we;
    logic [31:0]      ram_rdata;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    assign gnt     = (count_q != 2'd2);
    assign push    = req & gnt;
    assign pop     = (state_q == ST_RESP);
    assign count_d = count_q + {1'b0, push} - {1'b0, pop};

    // Counting the entry pushed this cycle lets an idle engine start on the
    // acceptance edge, which is what gives the LATENCY-1 edge response time.
    assign more_pending = (count_d != 2'd0);

    assign head          = fifo_q[rd_ptr_q];
    assign head_in_range = ((head.word_addr >> AW) == '0);
    assign head_is_read  = (head.wstrb == 4'b0000);

    assign ram_we   = (pop && head_in_range) ? head.wstrb : 4'b0000;
    assign data_gnt = pop;
    assign rdata    = (pop && head_is_read && head_in_range) ? ram_rdata : 32'h0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (more_pending) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= LAT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_q[wr_ptr_q] <= {addr[31:2], wdata, wstrb};
        end
    end

    ladybird_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (head.word_addr[AW-1:0]),
        .wdata_i (head.wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_ladybird_mem_responder.sv
// Bench for ladybird_mem_responder: three instances (LATENCY 1, 2, 3) checked
// every cycle against a transaction-level model of timing and storage.
module tb_ladybird_mem_responder;

    localparam int NI    = 3;
    localparam int DEPTH = 16;

    typedef struct {
        int          k;
        int          c;
        int          r;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_s      [NI];
    logic [31:0] addr_s     [NI];
    logic [31:0] wdata_s    [NI];
    logic [3:0]  wstrb_s    [NI];
    logic        gnt_s      [NI];
    logic        data_gnt_s [NI];
    logic [31:0] rdata_s    [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        ladybird_mem_responder #(
            .DEPTH   (DEPTH),
            .LATENCY (gi + 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req      (req_s[gi]),
            .gnt      (gnt_s[gi]),
            .addr     (addr_s[gi]),
            .wdata    (wdata_s[gi]),
            .wstrb    (wstrb_s[gi]),
            .data_gnt (data_gnt_s[gi]),
            .rdata    (rdata_s[gi])
        );
    end

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    bit          chk_en = 1'b0;
    ent_t        pend [$];
    int          last_r     [NI];
    logic [31:0] mem_m      [NI][DEPTH];
    int          pulses     [NI];
    logic [31:0] last_rdata [NI];
    int          edges2 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Model: response at capture edge + L - 1, never sooner than L after the
    // previous response; storage updated in response order.
    int          m_out, m_idx, m_w, m_r1, m_r2;
    logic        m_gnt, m_dg;
    logic [31:0] m_rd;
    ent_t        m_e;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                m_out = 0;
                m_idx = -1;
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].k == k) begin
                        m_out++;
                        if (m_idx < 0) m_idx = i;
                    end
                end
                m_gnt = (m_out < 2);
                m_dg  = 1'b0;
                m_rd  = 32'h0;
                if (m_idx >= 0 && pend[m_idx].r == cyc) begin
                    m_e = pend[m_idx];
                    pend.delete(m_idx);
                    m_dg = 1'b1;
                    if (m_e.a < 32'(DEPTH * 4)) begin
                        m_w = int'(m_e.a >> 2);
                        if (m_e.s == 4'b0000) begin
                            m_rd = mem_m[k][m_w];
                        end else begin
                            for (int b = 0; b < 4; b++) begin
                                if (m_e.s[b]) mem_m[k][m_w][b*8 +: 8] = m_e.d[b*8 +: 8];
                            end
                        end
                    end
                end
                chk($sformatf("gnt L=%0d cyc=%0d", k + 1, cyc), 32'(gnt_s[k]), 32'(m_gnt));
                chk($sformatf("data_gnt L=%0d cyc=%0d", k + 1, cyc), 32'(data_gnt_s[k]), 32'(m_dg));
                chk($sformatf("rdata L=%0d cyc=%0d", k + 1, cyc), rdata_s[k], m_rd);
                if (data_gnt_s[k] === 1'b1) begin
                    pulses[k]++;
                    last_rdata[k] = rdata_s[k];
                    if (k == 2) edges2.push_back(cyc);
                end
                if (rst !== 1'b1 && req_s[k] === 1'b1 && m_gnt) begin
                    m_e.k = k;
                    m_e.c = cyc + 1;
                    m_e.a = addr_s[k];
                    m_e.d = wdata_s[k];
                    m_e.s = wstrb_s[k];
                    m_r1  = m_e.c + k;
                    m_r2  = last_r[k] + k + 1;
                    m_e.r = (m_r1 > m_r2) ? m_r1 : m_r2;
                    last_r[k] = m_e.r;
                    pend.push_back(m_e);
                end
            end
            if (rst === 1'b1) begin
                pend.delete();
                for (int k = 0; k < NI; k++) last_r[k] = -1000;
            end
        end
    end

    // Leaves req high so consecutive calls form back-to-back requests.
    task automatic send(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit done = 1'b0;
        req_s[k]   = 1'b1;
        addr_s[k]  = a;
        wdata_s[k] = d;
        wstrb_s[k] = s;
        for (int t = 0; t < 64 && !done; t++) begin
            if (gnt_s[k] === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        chk($sformatf("accept L=%0d a=%h", k + 1, a), 32'(done), 32'd1);
    endtask

    task automatic idle(input int k, input int n);
        req_s[k] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && pend.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(pend.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int          p0, p2, n_edge, n3;
    logic [31:0] saved, r_a;
    logic [3:0]  r_s;
    int          gap;

    initial begin
        for (int k = 0; k < NI; k++) begin
            req_s[k]      = 1'b0;
            addr_s[k]     = 32'h0;
            wdata_s[k]    = 32'h0;
            wstrb_s[k]    = 4'h0;
            last_r[k]     = -1000;
            pulses[k]     = 0;
            last_rdata[k] = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset gnt L=%0d", k + 1), 32'(gnt_s[k]), 32'd1);
            chk($sformatf("reset data_gnt L=%0d", k + 1), 32'(data_gnt_s[k]), 32'd0);
            chk($sformatf("reset rdata L=%0d", k + 1), rdata_s[k], 32'h0);
        end
        @(posedge clk);
        #1;

        // Give every word a known value.
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < DEPTH; w++) send(k, 32'(w * 4), $urandom, 4'hF);
            idle(k, 0);
        end
        drain();

        // Write then read the same word, both queued.
        p0 = pulses[1];
        send(1, 32'h10, 32'hDEADBEEF, 4'hF);
        send(1, 32'h10, 32'h0, 4'h0);
        idle(1, 0);
        drain();
        chk("raw pulses", 32'(pulses[1] - p0), 32'd2);
        chk("raw rdata", last_rdata[1], 32'hDEADBEEF);

        // Partial byte write merges with existing contents.
        send(1, 32'h20, 32'h11223344, 4'hF);
        send(1, 32'h20, 32'h000000AA, 4'b0001);
        send(1, 32'h20, 32'h0, 4'h0);
        idle(1, 0);
        drain();
        chk("byte merge rdata", last_rdata[1], 32'h112233AA);

        // Out-of-range accesses still respond but touch nothing.
        p0 = pulses[1];
        send(1, 32'(DEPTH * 4 + 4), 32'h0, 4'h0);
        idle(1, 0);
        drain();
        chk("oor read pulse", 32'(pulses[1] - p0), 32'd1);
        chk("oor read rdata", last_rdata[1], 32'h0);
        saved = mem_m[1][1];
        send(1, 32'(DEPTH * 4 + 4), 32'hFFFFFFFF, 4'hF);
        send(1, 32'h4, 32'h0, 4'h0);
        idle(1, 0);
        drain();
        chk("oor write alias", last_rdata[1], saved);
        for (int w = 0; w < DEPTH; w++) send(1, 32'(w * 4), 32'h0, 4'h0);
        idle(1, 0);
        drain();

        // LATENCY=3, three requests with req held high.
        edges2.delete();
        send(2, 32'h30, 32'h0, 4'h0);
        n_edge = cyc;
        send(2, 32'h34, 32'h0, 4'h0);
        chk("lat3 gnt full", 32'(gnt_s[2]), 32'd0);
        send(2, 32'h38, 32'h0, 4'h0);
        n3 = cyc;
        idle(2, 0);
        drain();
        chk("lat3 third accept edge", 32'(n3), 32'(n_edge + 4));
        chk("lat3 pulse count", 32'(edges2.size()), 32'd3);
        chk("lat3 edge 1", 32'((edges2.size() > 0) ? edges2[0] : -1), 32'(n_edge + 2));
        chk("lat3 edge 2", 32'((edges2.size() > 1) ? edges2[1] : -1), 32'(n_edge + 5));
        chk("lat3 edge 3", 32'((edges2.size() > 2) ? edges2[2] : -1), 32'(n_edge + 8));

        // LATENCY=1 single read answers in the cycle right after acceptance.
        send(0, 32'h8, 32'h0, 4'h0);
        idle(0, 0);
        @(negedge clk);
        chk("lat1 data_gnt", 32'(data_gnt_s[0]), 32'd1);
        chk("lat1 gnt", 32'(gnt_s[0]), 32'd1);
        chk("lat1 rdata", rdata_s[0], mem_m[0][2]);
        drain();

        // Reset while two requests wait; a req during reset is ignored.
        saved = mem_m[2][4];
        p0 = pulses[0];
        p2 = pulses[2];
        send(2, 32'h10, 32'h0BADF00D, 4'hF);
        send(2, 32'h14, 32'h0, 4'h0);
        req_s[2]   = 1'b0;
        rst        = 1'b1;
        req_s[0]   = 1'b1;
        addr_s[0]  = 32'h0;
        wstrb_s[0] = 4'h0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        req_s[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("reset drop pulses L3", 32'(pulses[2] - p2), 32'd0);
        chk("reset ignore req L1", 32'(pulses[0] - p0), 32'd0);
        chk("post reset gnt", 32'(gnt_s[2]), 32'd1);
        send(2, 32'h10, 32'h0, 4'h0);
        idle(2, 0);
        drain();
        chk("storage survives reset", last_rdata[2], saved);

        // Random traffic with random gaps, some out of range.
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 40; i++) begin
                r_a = 32'($urandom_range(0, 19) * 4) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) r_a = r_a | 32'h4000_0000;
                r_s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                send(k, r_a, $urandom, r_s);
                gap = $urandom_range(0, 3);
                if (gap != 0) idle(k, gap);
            end
            idle(k, 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
